// File: rtl/scan_pkg.sv
// Shared types and helpers for the scan configuration blocks.
package scan_pkg;

   // Scan register FSM states.
   typedef enum logic [1:0] {
      StIdle,
      StShift,
      StUpdate
   } scan_state_e;

   // Chain length: data bits plus an optional trailing even-parity bit.
   function automatic int unsigned chain_len(input int unsigned width,
                                             input int unsigned parity_en);
      return width + ((parity_en != 0) ? 32'd1 : 32'd0);
   endfunction

endpackage

// File: rtl/scan_len_counter.sv
// Saturating bit counter with synchronous clear, used to measure shift length.
module scan_len_counter #(
   parameter int unsigned MAX_VAL = 10,
   parameter int unsigned CNT_W   = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Next count: clear wins, otherwise increment until saturated.
   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != CNT_W'(MAX_VAL))) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Count register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign count = cnt_q;

endmodule

// File: rtl/scan_cfg_reg.sv
// Scan-loadable configuration register with parity-checked shadow update.
module scan_cfg_reg
   import scan_pkg::*;
#(
   parameter int unsigned           WIDTH     = 8,
   parameter logic [WIDTH-1:0]      RESET_VAL = '0,
   parameter int unsigned           PARITY_EN = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             scan_en,
   input  logic             scan_in,
   output logic             scan_out,
   input  logic             scan_capture,
   input  logic [WIDTH-1:0] capture_in,
   input  logic             scan_update,
   output logic [WIDTH-1:0] d_out,
   output logic             upd_done,
   output logic             upd_err,
   output logic             busy
);

   localparam int unsigned CHAIN_LEN = chain_len(WIDTH, PARITY_EN);
   // One extra code above CHAIN_LEN marks an overrun.
   localparam int unsigned CNT_W     = $clog2(CHAIN_LEN + 2);

   logic [CHAIN_LEN-1:0] chain_q, chain_d;
   logic [WIDTH-1:0]     d_out_q, d_out_d;
   logic                 upd_done_q, upd_done_d;
   logic                 upd_err_q, upd_err_d;
   logic [CNT_W-1:0]     bit_cnt;
   logic                 do_capture, do_shift, do_update;
   logic                 parity_ok, accept;
   scan_state_e          state_q, state_d;

   // Strobe priority: capture over shift over update.
   always_comb begin
      do_capture = scan_capture;
      do_shift   = scan_en & ~scan_capture;
      do_update  = scan_update & ~scan_en & ~scan_capture;
   end

   scan_len_counter #(
      .MAX_VAL (CHAIN_LEN + 1),
      .CNT_W   (CNT_W)
   ) u_len_cnt (
      .clk   (clk),
      .reset (reset),
      .clear (do_capture | do_update),
      .inc   (do_shift),
      .count (bit_cnt)
   );

   // Update is legal only after exactly CHAIN_LEN shifts with even parity.
   always_comb begin
      parity_ok = (PARITY_EN == 0) || (^chain_q == 1'b0);
      accept    = (bit_cnt == CNT_W'(CHAIN_LEN)) && parity_ok;
   end

   // Chain next state: capture loads status plus parity, shift moves toward MSB.
   always_comb begin
      chain_d = chain_q;
      if (do_capture) begin
         chain_d[CHAIN_LEN-1 -: WIDTH] = capture_in;
         if (PARITY_EN != 0) begin
            chain_d[0] = ^capture_in;
         end
      end else if (do_shift) begin
         chain_d = {chain_q[CHAIN_LEN-2:0], scan_in};
      end
   end

   // Shadow register and update status next state.
   always_comb begin
      d_out_d    = d_out_q;
      upd_err_d  = upd_err_q;
      upd_done_d = 1'b0;
      if (do_update) begin
         if (accept) begin
            d_out_d    = chain_q[CHAIN_LEN-1 -: WIDTH];
            upd_done_d = 1'b1;
            upd_err_d  = 1'b0;
         end else begin
            upd_err_d  = 1'b1;
         end
      end
   end

   // Datapath registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         chain_q    <= '0;
         d_out_q    <= RESET_VAL;
         upd_done_q <= 1'b0;
         upd_err_q  <= 1'b0;
      end else begin
         chain_q    <= chain_d;
         d_out_q    <= d_out_d;
         upd_done_q <= upd_done_d;
         upd_err_q  <= upd_err_d;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state; an effective update overrides every other transition.
   always_comb begin
      state_d = state_q;
      if (do_update) begin
         state_d = StUpdate;
      end else begin
         unique case (state_q)
            StIdle:   if (do_shift) state_d = StShift;
            StShift:  if (do_capture) state_d = StIdle;
            StUpdate: state_d = do_shift ? StShift : StIdle;
            default:  state_d = StIdle;
         endcase
      end
   end

   // FSM and datapath outputs.
   always_comb begin
      busy     = (state_q == StShift);
      scan_out = chain_q[CHAIN_LEN-1];
      d_out    = d_out_q;
      upd_done = upd_done_q;
      upd_err  = upd_err_q;
   end

endmodule

// File: tb/tb_scan_cfg_reg.sv
// Directed self-checking bench for scan_cfg_reg (WIDTH=8, PARITY_EN=1).
module tb_scan_cfg_reg;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       scan_en = 1'b0;
   logic       scan_in = 1'b0;
   logic       scan_capture = 1'b0;
   logic       scan_update = 1'b0;
   logic [7:0] capture_in = 8'h00;
   logic       scan_out;
   logic [7:0] d_out;
   logic       upd_done;
   logic       upd_err;
   logic       busy;

   int checks = 0;
   int errors = 0;

   scan_cfg_reg #(
      .WIDTH     (8),
      .RESET_VAL (8'h00),
      .PARITY_EN (1)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .scan_en      (scan_en),
      .scan_in      (scan_in),
      .scan_out     (scan_out),
      .scan_capture (scan_capture),
      .capture_in   (capture_in),
      .scan_update  (scan_update),
      .d_out        (d_out),
      .upd_done     (upd_done),
      .upd_err      (upd_err),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic shift_bit(input logic b);
      scan_en = 1'b1;
      scan_in = b;
      tick();
      scan_en = 1'b0;
      scan_in = 1'b0;
   endtask

   task automatic shift_byte(input logic [7:0] v);
      for (int i = 7; i >= 0; i--) shift_bit(v[i]);
   endtask

   task automatic do_update();
      scan_update = 1'b1;
      tick();
      scan_update = 1'b0;
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      #2;
      reset = 1'b0;
      tick();
   endtask

   logic [8:0] exp_out;

   initial begin
      // Reset state
      tick();
      tick();
      check("rst_d_out", 32'(d_out), 32'h00);
      check("rst_scan_out", 32'(scan_out), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_upd_done", 32'(upd_done), 32'h0);
      check("rst_upd_err", 32'(upd_err), 32'h0);
      reset = 1'b0;
      tick();

      // Full 9-bit load of 0xA5 with even parity 0, then update
      shift_bit(1'b1);
      check("shift_busy", 32'(busy), 32'h1);
      shift_bit(1'b0); shift_bit(1'b1); shift_bit(1'b0);
      shift_bit(1'b0); shift_bit(1'b1); shift_bit(1'b0); shift_bit(1'b1);
      shift_bit(1'b0);
      check("a5_pre_d_out", 32'(d_out), 32'h00);
      do_update();
      check("a5_d_out", 32'(d_out), 32'hA5);
      check("a5_upd_done", 32'(upd_done), 32'h1);
      check("a5_upd_err", 32'(upd_err), 32'h0);
      check("a5_busy_upd", 32'(busy), 32'h0);
      tick();
      check("a5_upd_done_pulse", 32'(upd_done), 32'h0);
      check("a5_d_out_hold", 32'(d_out), 32'hA5);

      // Short load (8 bits) is rejected, then a correct load is accepted
      pulse_reset();
      shift_byte(8'hA5);
      do_update();
      check("short_upd_err", 32'(upd_err), 32'h1);
      check("short_d_out", 32'(d_out), 32'h00);
      check("short_upd_done", 32'(upd_done), 32'h0);
      shift_byte(8'hA5);
      shift_bit(1'b0);
      do_update();
      check("reload_d_out", 32'(d_out), 32'hA5);
      check("reload_upd_err", 32'(upd_err), 32'h0);
      check("reload_upd_done", 32'(upd_done), 32'h1);

      // Bad parity is rejected
      pulse_reset();
      shift_byte(8'hA5);
      shift_bit(1'b1);
      do_update();
      check("par_upd_err", 32'(upd_err), 32'h1);
      check("par_d_out", 32'(d_out), 32'h00);
      check("par_upd_done", 32'(upd_done), 32'h0);

      // Overrun: 10 shifts leave a valid-looking chain but still reject
      pulse_reset();
      shift_bit(1'b0);
      shift_byte(8'hA5);
      shift_bit(1'b0);
      do_update();
      check("ovr_upd_err", 32'(upd_err), 32'h1);
      check("ovr_d_out", 32'(d_out), 32'h00);

      // Capture 0x3C and shift it out MSB first
      capture_in = 8'h3C;
      scan_capture = 1'b1;
      tick();
      scan_capture = 1'b0;
      check("cap_busy", 32'(busy), 32'h0);
      exp_out = 9'b0_0111_1000;
      for (int i = 8; i >= 0; i--) begin
         check($sformatf("cap_scan_out_%0d", 8 - i), 32'(scan_out), 32'(exp_out[i]));
         shift_bit(1'b0);
      end
      check("cap_d_out", 32'(d_out), 32'h00);
      check("cap_upd_err", 32'(upd_err), 32'h1);

      // All three strobes together: capture only
      capture_in = 8'h81;
      scan_capture = 1'b1;
      scan_en = 1'b1;
      scan_update = 1'b1;
      tick();
      scan_capture = 1'b0;
      scan_en = 1'b0;
      scan_update = 1'b0;
      check("all_cnt", 32'(dut.bit_cnt), 32'h0);
      check("all_upd_done", 32'(upd_done), 32'h0);
      check("all_upd_err", 32'(upd_err), 32'h1);
      check("all_scan_out", 32'(scan_out), 32'h1);
      check("all_busy", 32'(busy), 32'h0);
      check("all_d_out", 32'(d_out), 32'h00);
      shift_byte(8'hA5);
      shift_bit(1'b0);
      do_update();
      check("all_then_load_d_out", 32'(d_out), 32'hA5);
      check("all_then_load_err", 32'(upd_err), 32'h0);

      // Asynchronous reset mid-shift
      shift_bit(1'b1); shift_bit(1'b1); shift_bit(1'b1); shift_bit(1'b1); shift_bit(1'b1);
      check("mid_busy_pre", 32'(busy), 32'h1);
      reset = 1'b1;
      #1;
      check("mid_chain", 32'(dut.chain_q), 32'h0);
      check("mid_scan_out", 32'(scan_out), 32'h0);
      check("mid_d_out", 32'(d_out), 32'h00);
      check("mid_busy", 32'(busy), 32'h0);
      #1;
      reset = 1'b0;
      do_update();
      check("mid_upd_err", 32'(upd_err), 32'h1);
      check("mid_upd_done", 32'(upd_done), 32'h0);
      check("mid_d_out_after", 32'(d_out), 32'h00);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
